// File: rtl/jtag_ahb_sequencer.sv
// Single-transfer AHB-Lite master driven by the JTAG TAP's AHBL ADDRESS/WRITE/READ
// instructions; keeps the address register, captured read data and sticky status.
module jtag_ahb_sequencer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          AUTO_INC   = 1'b1,
  parameter int unsigned INC_STEP   = 4
) (
  input  logic                  TCK,
  input  logic                  TRST,
  input  logic                  CMD_VALID,
  input  logic [1:0]            CMD,
  input  logic [DATA_WIDTH-1:0] CMD_DATA,
  input  logic                  CLR_STATUS,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [3:0]            STATUS
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_e;

  localparam logic [1:0] CMD_NOP      = 2'b00;
  localparam logic [1:0] CMD_SET_ADDR = 2'b01;
  localparam logic [1:0] CMD_WRITE    = 2'b10;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_e                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] addr_reg_q, addr_reg_d;
  logic [ADDR_WIDTH-1:0] haddr_q,    haddr_d;
  logic                  hwrite_q,   hwrite_d;
  logic [DATA_WIDTH-1:0] hwdata_q,   hwdata_d;
  logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
  logic                  done_q,     done_d;
  logic                  err_q,      err_d;
  logic                  ovr_q,      ovr_d;
  logic                  cmd_active;

  assign cmd_active = CMD_VALID && (CMD != CMD_NOP);

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
    state_d    = state_q;
    addr_reg_d = addr_reg_q;
    haddr_d    = haddr_q;
    hwrite_d   = hwrite_q;
    hwdata_d   = hwdata_q;
    rdata_d    = rdata_q;
    done_d     = done_q;
    err_d      = err_q;
    ovr_d      = ovr_q;

    // Clear first so a coincident set event below overrides it.
    if (CLR_STATUS) begin
      done_d = 1'b0;
      err_d  = 1'b0;
      ovr_d  = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_active) begin
          if (CMD == CMD_SET_ADDR) begin
            addr_reg_d = ADDR_WIDTH'(CMD_DATA);
          end else begin
            state_d  = ST_ADDR;
            haddr_d  = addr_reg_q;
            hwrite_d = (CMD == CMD_WRITE);
            if (CMD == CMD_WRITE) hwdata_d = CMD_DATA;
            done_d   = 1'b0;
          end
        end
      end
      ST_ADDR: begin
        if (cmd_active) ovr_d = 1'b1;
        if (HREADY) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (cmd_active) ovr_d = 1'b1;
        if (HREADY) begin
          state_d = ST_IDLE;
          if (HRESP) begin
            err_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (!hwrite_q) rdata_d = HRDATA;
            if (AUTO_INC) addr_reg_d = addr_reg_q + ADDR_WIDTH'(INC_STEP);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      state_q    <= ST_IDLE;
      addr_reg_q <= '0;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_reg_q <= addr_reg_d;
      haddr_q    <= haddr_d;
      hwrite_q   <= hwrite_d;
      hwdata_q   <= hwdata_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
    end
  end

  // HTRANS decodes straight off the state flop, so reset idles the bus without waiting for an edge.
  assign HTRANS = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR  = haddr_q;
  assign HWRITE = hwrite_q;
  assign HSIZE  = 3'b010;
  assign HWDATA = hwdata_q;
  assign RDATA  = rdata_q;
  assign STATUS = {ovr_q, err_q, done_q, (state_q != ST_IDLE)};

endmodule

// File: tb/tb_jtag_ahb_sequencer.sv
// Self-checking bench for jtag_ahb_sequencer: expected address phases are queued when a
// command is issued and popped when the DUT drives NONSEQ.
module tb_jtag_ahb_sequencer;

  localparam logic [1:0] C_NOP = 2'b00, C_SET = 2'b01, C_WR = 2'b10, C_RD = 2'b11;

  logic        TCK, TRST, CMD_VALID, CLR_STATUS, HWRITE, HREADY, HRESP;
  logic [1:0]  CMD, HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  STATUS;
  logic [31:0] CMD_DATA, HADDR, HWDATA, HRDATA, RDATA;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] model_rdata;

  jtag_ahb_sequencer dut (
    .TCK(TCK), .TRST(TRST), .CMD_VALID(CMD_VALID), .CMD(CMD), .CMD_DATA(CMD_DATA),
    .CLR_STATUS(CLR_STATUS), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .RDATA(RDATA), .STATUS(STATUS)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  // Strobe one command for exactly one rising edge; returns at the negedge after that edge.
  task automatic send_cmd(input logic [1:0] c, input logic [31:0] d);
    @(negedge TCK);
    CMD_VALID = 1'b1; CMD = c; CMD_DATA = d;
    @(negedge TCK);
    CMD_VALID = 1'b0; CMD = C_NOP; CMD_DATA = '0;
  endtask

  task automatic clear_status();
    @(negedge TCK);
    CLR_STATUS = 1'b1;
    @(negedge TCK);
    CLR_STATUS = 1'b0;
  endtask

  // Pop the oldest expected address phase and compare it with the bus right now.
  task automatic pop_xfer(input string name);
    xfer_t e;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: NONSEQ seen with empty scoreboard (haddr=%h)", name, HADDR);
    end else begin
      e = exp_q.pop_front();
      if (HTRANS !== 2'b10 || HADDR !== e.addr || HWRITE !== e.wr || (e.wr && HWDATA !== e.wdata)) begin
        tests_failed++;
        $display("FAIL %s: got htrans=%b haddr=%h hwrite=%b hwdata=%h, expected htrans=10 haddr=%h hwrite=%b hwdata=%h",
                 name, HTRANS, HADDR, HWRITE, HWDATA, e.addr, e.wr, e.wdata);
      end
    end
  endtask

  // Count busy cycles (sampled at negedges) until IDLE, bounded.
  task automatic wait_idle(input string name, output int busy_cycles);
    busy_cycles = 0;
    while (STATUS[0] === 1'b1 && busy_cycles < 64) begin
      busy_cycles++;
      @(negedge TCK);
    end
    tests_run++;
    if (STATUS[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: busy still %b after %0d cycles, expected 0", name, STATUS[0], busy_cycles);
    end
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (HTRANS !== 2'b00 || STATUS !== 4'b0000 || HADDR !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_asserted: htrans=%b status=%b haddr=%h, expected 00 0000 0", HTRANS, STATUS, HADDR);
    end
    @(negedge TCK);
    TRST = 1'b0;
    @(negedge TCK);
    tests_run++;
    if (HADDR !== 32'h0 || HTRANS !== 2'b00 || HWRITE !== 1'b0 || HSIZE !== 3'b010 ||
        HWDATA !== 32'h0 || RDATA !== 32'h0 || STATUS !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_values: haddr=%h htrans=%b hwrite=%b hsize=%b hwdata=%h rdata=%h status=%b, expected 0 00 0 010 0 0 0000",
               HADDR, HTRANS, HWRITE, HSIZE, HWDATA, RDATA, STATUS);
    end
    model_rdata = 32'h0;
  endtask

  task automatic test_read_basic();
    int n;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0000_F00F;
    send_cmd(C_SET, 32'h0000_1000);
    tests_run++;
    if (STATUS !== 4'b0000 || HTRANS !== 2'b00) begin
      tests_failed++;
      $display("FAIL set_addr_no_bus: status=%b htrans=%b, expected 0000 00", STATUS, HTRANS);
    end
    exp_q.push_back('{32'h0000_1000, 1'b0, 32'h0});
    send_cmd(C_RD, 32'hFFFF_FFFF);
    pop_xfer("read_addr_phase");
    wait_idle("read_idle", n);
    model_rdata = 32'h0000_F00F;
    tests_run++;
    if (n != 2 || STATUS !== 4'b0010 || RDATA !== model_rdata) begin
      tests_failed++;
      $display("FAIL read_result: busy=%0d status=%b rdata=%h, expected 2 0010 %h", n, STATUS, RDATA, model_rdata);
    end
    HRDATA = 32'h1234_5678;
    exp_q.push_back('{32'h0000_1004, 1'b0, 32'h0});
    send_cmd(C_RD, 32'h0);
    pop_xfer("read_autoinc_addr");
    wait_idle("read2_idle", n);
    model_rdata = 32'h1234_5678;
    tests_run++;
    if (RDATA !== model_rdata) begin
      tests_failed++;
      $display("FAIL read2_rdata: rdata=%h, expected %h", RDATA, model_rdata);
    end
  endtask

  task automatic test_write_wait();
    int busy, bad_hold, early_done;
    busy = 0; bad_hold = 0; early_done = 0;
    send_cmd(C_SET, 32'h0000_2000);
    exp_q.push_back('{32'h0000_2000, 1'b1, 32'hDEAD_BEEF});
    send_cmd(C_WR, 32'hDEAD_BEEF);
    pop_xfer("write_addr_phase");
    for (int i = 0; i < 16; i++) begin
      if (STATUS[0] !== 1'b1) break;
      busy++;
      if (i > 0 && (HWDATA !== 32'hDEAD_BEEF || HTRANS !== 2'b00)) bad_hold++;
      if (STATUS[1] !== 1'b0) early_done++;
      HREADY = (i >= 1 && i <= 3) ? 1'b0 : 1'b1;
      @(negedge TCK);
    end
    HREADY = 1'b1;
    tests_run++;
    if (busy != 5) begin
      tests_failed++;
      $display("FAIL write_busy_cycles: got %0d, expected 5", busy);
    end
    tests_run++;
    if (bad_hold != 0 || early_done != 0) begin
      tests_failed++;
      $display("FAIL write_wait_hold: hwdata/htrans bad in %0d cycles, done early in %0d cycles, expected 0 0", bad_hold, early_done);
    end
    tests_run++;
    if (STATUS !== 4'b0010 || HWDATA !== 32'hDEAD_BEEF || RDATA !== model_rdata) begin
      tests_failed++;
      $display("FAIL write_done: status=%b hwdata=%h rdata=%h, expected 0010 deadbeef %h", STATUS, HWDATA, RDATA, model_rdata);
    end
  endtask

  task automatic test_error();
    int n;
    send_cmd(C_SET, 32'h0000_3000);
    exp_q.push_back('{32'h0000_3000, 1'b0, 32'h0});
    send_cmd(C_RD, 32'h0);
    pop_xfer("err_addr_phase");
    HRDATA = 32'hBAD0_BAD0;
    @(negedge TCK);
    HREADY = 1'b0; HRESP = 1'b1;
    @(negedge TCK);
    tests_run++;
    if (STATUS[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_first_cycle_busy: busy=%b, expected 1", STATUS[0]);
    end
    HREADY = 1'b1; HRESP = 1'b1;
    @(negedge TCK);
    HRESP = 1'b0;
    tests_run++;
    if (STATUS !== 4'b0100 || RDATA !== model_rdata) begin
      tests_failed++;
      $display("FAIL err_status: status=%b rdata=%h, expected 0100 %h", STATUS, RDATA, model_rdata);
    end
    clear_status();
    tests_run++;
    if (STATUS !== 4'b0000) begin
      tests_failed++;
      $display("FAIL err_clear: status=%b, expected 0000", STATUS);
    end
    HRDATA = 32'hCAFE_F00D;
    exp_q.push_back('{32'h0000_3000, 1'b0, 32'h0});
    send_cmd(C_RD, 32'h0);
    pop_xfer("err_addr_not_incremented");
    wait_idle("err_retry_idle", n);
    model_rdata = 32'hCAFE_F00D;
    tests_run++;
    if (RDATA !== model_rdata || STATUS !== 4'b0010) begin
      tests_failed++;
      $display("FAIL err_retry: rdata=%h status=%b, expected %h 0010", RDATA, STATUS, model_rdata);
    end
  endtask

  task automatic test_overrun();
    int n, nonseq;
    nonseq = 0;
    send_cmd(C_SET, 32'h0000_4000);
    exp_q.push_back('{32'h0000_4000, 1'b1, 32'h55AA_55AA});
    @(negedge TCK);
    CMD_VALID = 1'b1; CMD = C_WR; CMD_DATA = 32'h55AA_55AA;
    @(negedge TCK);
    pop_xfer("ovr_addr_phase");
    for (int i = 0; i < 8; i++) begin
      if (HTRANS === 2'b10) nonseq++;
      if (i == 0) begin CMD = C_RD; CMD_DATA = 32'h0; end
      if (i == 1) begin CMD_VALID = 1'b0; CMD = C_NOP; end
      @(negedge TCK);
    end
    tests_run++;
    if (nonseq != 1 || STATUS !== 4'b1010) begin
      tests_failed++;
      $display("FAIL ovr_dropped: nonseq=%0d status=%b, expected 1 1010", nonseq, STATUS);
    end
    clear_status();
    tests_run++;
    if (STATUS !== 4'b0000) begin
      tests_failed++;
      $display("FAIL ovr_clear: status=%b, expected 0000", STATUS);
    end
    // NOP while busy must not raise overrun.
    exp_q.push_back('{32'h0000_4004, 1'b0, 32'h0});
    send_cmd(C_RD, 32'h0);
    pop_xfer("ovr_addr_after_write");
    CMD_VALID = 1'b1; CMD = C_NOP;
    @(negedge TCK);
    CMD_VALID = 1'b0;
    wait_idle("nop_idle", n);
    tests_run++;
    if (STATUS !== 4'b0010) begin
      tests_failed++;
      $display("FAIL nop_while_busy: status=%b, expected 0010", STATUS);
    end
    // Overrun set coinciding with CLR_STATUS: set wins; dropped SET_ADDR leaves address alone.
    exp_q.push_back('{32'h0000_4008, 1'b0, 32'h0});
    send_cmd(C_RD, 32'h0);
    pop_xfer("clr_vs_set_addr");
    CMD_VALID = 1'b1; CMD = C_SET; CMD_DATA = 32'h0000_9999; CLR_STATUS = 1'b1;
    @(negedge TCK);
    CMD_VALID = 1'b0; CMD = C_NOP; CMD_DATA = '0; CLR_STATUS = 1'b0;
    wait_idle("clr_vs_set_idle", n);
    tests_run++;
    if (STATUS !== 4'b1010) begin
      tests_failed++;
      $display("FAIL clr_vs_set: status=%b, expected 1010", STATUS);
    end
    exp_q.push_back('{32'h0000_400C, 1'b0, 32'h0});
    send_cmd(C_RD, 32'h0);
    pop_xfer("dropped_set_addr_ignored");
    wait_idle("ovr_final_idle", n);
  endtask

  task automatic test_back_to_back_wrap();
    int n;
    clear_status();
    send_cmd(C_SET, 32'hFFFF_FFFC);
    exp_q.push_back('{32'hFFFF_FFFC, 1'b0, 32'h0});
    exp_q.push_back('{32'h0000_0000, 1'b0, 32'h0});
    send_cmd(C_RD, 32'h0);
    pop_xfer("wrap_first");
    wait_idle("wrap_first_idle", n);
    send_cmd(C_RD, 32'h0);
    pop_xfer("wrap_second");
    wait_idle("wrap_second_idle", n);
    tests_run++;
    if (STATUS !== 4'b0010 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL wrap_end: status=%b pending=%0d, expected 0010 0", STATUS, exp_q.size());
    end
  endtask

  task automatic test_trst_mid_transfer();
    int n;
    send_cmd(C_SET, 32'h0000_5000);
    HREADY = 1'b0;
    exp_q.push_back('{32'h0000_5000, 1'b0, 32'h0});
    send_cmd(C_RD, 32'h0);
    pop_xfer("trst_addr_phase");
    @(negedge TCK);
    tests_run++;
    if (HTRANS !== 2'b10 || HADDR !== 32'h0000_5000 || HWRITE !== 1'b0) begin
      tests_failed++;
      $display("FAIL addr_hold: htrans=%b haddr=%h hwrite=%b, expected 10 00005000 0", HTRANS, HADDR, HWRITE);
    end
    #2 TRST = 1'b1;
    #1;
    tests_run++;
    if (HTRANS !== 2'b00 || STATUS !== 4'b0000 || HADDR !== 32'h0) begin
      tests_failed++;
      $display("FAIL trst_immediate: htrans=%b status=%b haddr=%h, expected 00 0000 0", HTRANS, STATUS, HADDR);
    end
    @(negedge TCK);
    TRST = 1'b0; HREADY = 1'b1;
    @(negedge TCK);
    tests_run++;
    if (STATUS !== 4'b0000 || HADDR !== 32'h0 || RDATA !== 32'h0 || HWDATA !== 32'h0 || HTRANS !== 2'b00) begin
      tests_failed++;
      $display("FAIL trst_release: status=%b haddr=%h rdata=%h hwdata=%h htrans=%b, expected 0000 0 0 0 00",
               STATUS, HADDR, RDATA, HWDATA, HTRANS);
    end
    exp_q.push_back('{32'h0000_0000, 1'b0, 32'h0});
    send_cmd(C_RD, 32'h0);
    pop_xfer("trst_addr_reg_cleared");
    wait_idle("trst_read_idle", n);
  endtask

  initial begin
    TRST = 1'b1; CMD_VALID = 1'b0; CMD = C_NOP; CMD_DATA = '0; CLR_STATUS = 1'b0;
    HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    test_reset();
    test_read_basic();
    test_write_wait();
    test_error();
    test_overrun();
    test_back_to_back_wrap();
    test_trst_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
